// File: rtl/pixel_pattern_gen.sv
// Raster pattern source (solid, 8 colour bars, grey ramp, tiled ROM image; ROM path under PIXEL_PATTERN_GEN_ROM_EN).
// Fetch stage + 2-entry FIFO: pixel (0,0) valid two edges after reset release; issue stalls, holding counters, while the FIFO is full.
module pixel_pattern_gen #(
  parameter int H_ACTIVE   = 1920,
  parameter int V_ACTIVE   = 1080,
  parameter int DATA_WIDTH = 24,
  parameter int IMG_W_BITS = 8,
  parameter int IMG_H_BITS = 8
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [1:0]                       mode,
  input  logic [DATA_WIDTH-1:0]            solidColour,
  input  logic                             pixelReady,
  output logic                             pixelValid,
  output logic [DATA_WIDTH-1:0]            dataOutput,
  output logic                             startOfFrame,
  output logic                             endOfLine,
  output logic [IMG_W_BITS+IMG_H_BITS-1:0] romAddress,
  input  logic [DATA_WIDTH-1:0]            romData
);

  localparam int CW  = DATA_WIDTH / 3;
  localparam int BW  = H_ACTIVE / 8;
  localparam int HB  = $clog2(H_ACTIVE);
  localparam int VB  = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
  localparam int XW0 = (HB > IMG_W_BITS) ? HB : IMG_W_BITS;
  localparam int XW  = (XW0 > CW) ? XW0 : CW;
  localparam int YW  = (VB > IMG_H_BITS) ? VB : IMG_H_BITS;

  typedef struct packed {
    logic                  sof;
    logic                  eol;
    logic [DATA_WIDTH-1:0] dat;
  } pix_t;

  logic [XW-1:0]         x_q, x_d;
  logic [YW-1:0]         y_q, y_d;
  logic [XW-1:0]         bar_cnt_q, bar_cnt_d;
  logic [2:0]            bar_idx_q, bar_idx_d;
  logic [1:0]            mode_q;
  logic [DATA_WIDTH-1:0] solid_q;
  logic                  pend_vld_q;
  logic                  pend_rom_q;
  pix_t                  pend_q;
  pix_t                  fifo_q [2];
  logic                  rd_ptr_q, wr_ptr_q;
  logic [1:0]            cnt_q, cnt_d;

  logic                  first_px, last_x, last_y;
  logic                  pop, push, issue;
  logic [1:0]            occ;
  logic [1:0]            mode_eff;
  logic [DATA_WIDTH-1:0] solid_eff;
  logic [2:0]            rgb;
  logic [DATA_WIDTH-1:0] pix_dat_d;
  logic                  pix_rom_d;
  logic [DATA_WIDTH-1:0] push_dat;

  assign pixelValid   = (cnt_q != 2'd0);
  assign dataOutput   = fifo_q[rd_ptr_q].dat;
  assign startOfFrame = fifo_q[rd_ptr_q].sof;
  assign endOfLine    = fifo_q[rd_ptr_q].eol;

`ifdef PIXEL_PATTERN_GEN_ROM_EN
  assign romAddress = {y_q[IMG_H_BITS-1:0], x_q[IMG_W_BITS-1:0]};
  assign push_dat   = pend_rom_q ? romData : pend_q.dat;
`else
  logic unused_rom;
  assign romAddress = '0;
  assign push_dat   = pend_q.dat;
  assign unused_rom = ^{romData, pend_rom_q};
`endif

  always_comb begin
    first_px  = (x_q == '0) && (y_q == '0);
    last_x    = (x_q == XW'(H_ACTIVE - 1));
    last_y    = (y_q == YW'(V_ACTIVE - 1));
    pop       = pixelValid && pixelReady;
    push      = pend_vld_q;
    occ       = cnt_q + {1'b0, pend_vld_q};
    issue     = (occ < 2'd2) || ((occ == 2'd2) && pop);
    cnt_d     = cnt_q + {1'b0, push} - {1'b0, pop};
    // Pixel (0,0) uses the live inputs, since that is the cycle they get latched.
    mode_eff  = first_px ? mode : mode_q;
    solid_eff = first_px ? solidColour : solid_q;

    case (bar_idx_q)
      3'd0:    rgb = 3'b111;
      3'd1:    rgb = 3'b110;
      3'd2:    rgb = 3'b011;
      3'd3:    rgb = 3'b010;
      3'd4:    rgb = 3'b101;
      3'd5:    rgb = 3'b100;
      3'd6:    rgb = 3'b001;
      default: rgb = 3'b000;
    endcase

    pix_rom_d = 1'b0;
    case (mode_eff)
      2'd1:    pix_dat_d = {{CW{rgb[2]}}, {CW{rgb[1]}}, {CW{rgb[0]}}};
      2'd2:    pix_dat_d = {3{x_q[CW-1:0]}};
`ifdef PIXEL_PATTERN_GEN_ROM_EN
      2'd3: begin
        pix_dat_d = '0;
        pix_rom_d = 1'b1;
      end
`endif
      default: pix_dat_d = solid_eff;
    endcase

    x_d       = x_q + XW'(1);
    y_d       = y_q;
    bar_cnt_d = bar_cnt_q + XW'(1);
    bar_idx_d = bar_idx_q;
    if (last_x) begin
      x_d       = '0;
      y_d       = last_y ? '0 : y_q + YW'(1);
      bar_cnt_d = '0;
      bar_idx_d = 3'd0;
    end else if (bar_cnt_q == XW'(BW - 1)) begin
      // Last bar saturates so it absorbs the H_ACTIVE % 8 remainder.
      bar_cnt_d = '0;
      bar_idx_d = (bar_idx_q == 3'd7) ? 3'd7 : bar_idx_q + 3'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      x_q        <= '0;
      y_q        <= '0;
      bar_cnt_q  <= '0;
      bar_idx_q  <= 3'd0;
      mode_q     <= 2'd0;
      solid_q    <= '0;
      pend_vld_q <= 1'b0;
      pend_rom_q <= 1'b0;
      pend_q     <= '0;
      fifo_q[0]  <= '0;
      fifo_q[1]  <= '0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      cnt_q      <= 2'd0;
    end else begin
      cnt_q      <= cnt_d;
      pend_vld_q <= issue;
      if (issue) begin
        x_q        <= x_d;
        y_q        <= y_d;
        bar_cnt_q  <= bar_cnt_d;
        bar_idx_q  <= bar_idx_d;
        pend_q     <= {first_px, last_x, pix_dat_d};
        pend_rom_q <= pix_rom_d;
        if (first_px) begin
          mode_q  <= mode;
          solid_q <= solidColour;
        end
      end
      if (push) begin
        fifo_q[wr_ptr_q] <= {pend_q.sof, pend_q.eol, push_dat};
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
    end
  end

endmodule
